// File: rtl/ofs_plat_log_trace_drain.sv
// Platform event trace ring: monitors push tagged records, a reader drains them FWFT.
// Events lost to overflow are counted and re-inserted into the stream as drop markers.
module ofs_plat_log_trace_drain #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 64,
   parameter int INST_WIDTH = 8,
   parameter int TS_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     ev_valid,
   input  logic [1:0]               ev_class,
   input  logic [INST_WIDTH-1:0]    ev_instance,
   input  logic [DATA_WIDTH-1:0]    ev_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_class,
   output logic [INST_WIDTH-1:0]    out_instance,
   output logic [TS_WIDTH-1:0]      out_ts,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_is_drop,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [31:0]              drop_total
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic                  is_drop;
      logic [1:0]            cls;
      logic [INST_WIDTH-1:0] inst;
      logic [TS_WIDTH-1:0]   ts;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t              mem_q [DEPTH];
   entry_t              wr_entry;
   entry_t              head;

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [15:0]         pend_q, pend_d;
   logic [31:0]         drop_total_q, drop_total_d;

   logic ev_real;
   logic full;
   logic pop;
   logic write_marker;
   logic write_event;
   logic ev_dropped;
   logic push;
   logic mem_we;

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      ev_real      = ev_valid && (ev_class != 2'd0);
      // Full is judged from the registered count; a same-cycle pop never makes room.
      full         = (count_q == CNT_W'(DEPTH));
      pop          = (count_q != '0) && out_ready;
      write_marker = !full && (pend_q != 16'd0);
      write_event  = !full && (pend_q == 16'd0) && ev_real;
      ev_dropped   = ev_real && (full || write_marker);
      push         = write_marker || write_event;

      wr_entry = '0;
      if (write_marker) begin
         wr_entry.is_drop = 1'b1;
         wr_entry.ts      = ts_q;
         wr_entry.data    = DATA_WIDTH'(pend_q);
      end else begin
         wr_entry.cls  = ev_class;
         wr_entry.inst = ev_instance;
         wr_entry.ts   = ts_q;
         wr_entry.data = ev_data;
      end

      ts_d         = ts_q + TS_WIDTH'(1);
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      pend_d       = pend_q;
      drop_total_d = drop_total_q;
      mem_we       = 1'b0;

      if (flush) begin
         // Flush discards the ring and anything offered this cycle; lifetime drop count survives.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         pend_d   = 16'd0;
      end else begin
         mem_we = push;
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);

         if (write_marker)
            pend_d = ev_dropped ? 16'd1 : 16'd0;
         else if (ev_dropped && (pend_q != 16'hFFFF))
            pend_d = pend_q + 16'd1;

         if (ev_dropped && (drop_total_q != 32'hFFFF_FFFF))
            drop_total_d = drop_total_q + 32'd1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ts_q         <= '0;
         pend_q       <= 16'd0;
         drop_total_q <= 32'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ts_q         <= ts_d;
         pend_q       <= pend_d;
         drop_total_q <= drop_total_d;
      end
   end

   // NOTE: storage has no reset; the read side masks it with out_valid so stale contents never show.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Head is read combinationally from the registered read pointer; the write pointer never
   // aliases it while the ring holds data, so the head stays stable during a stall.
   assign head = mem_q[rd_ptr_q];

   always_comb begin
      out_valid    = (count_q != '0);
      out_class    = '0;
      out_instance = '0;
      out_ts       = '0;
      out_data     = '0;
      out_is_drop  = 1'b0;
      if (out_valid) begin
         out_class    = head.cls;
         out_instance = head.inst;
         out_ts       = head.ts;
         out_data     = head.data;
         out_is_drop  = head.is_drop;
      end
   end

   assign fill_level = count_q;
   assign drop_total = drop_total_q;

endmodule

// File: tb/tb_ofs_plat_log_trace_drain.sv
// Bench for the trace drain ring: a DEPTH=64 and a DEPTH=4 instance, each compared
// every cycle against a queue-based model, plus literal checks for the scripted scenarios.
module tb_ofs_plat_log_trace_drain;

   typedef struct packed {
      logic        drop;
      logic [1:0]  cls;
      logic [7:0]  inst;
      logic [31:0] ts;
      logic [63:0] data;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        flush_i    [2];
   logic        ev_valid_i [2];
   logic [1:0]  ev_class_i [2];
   logic [7:0]  ev_inst_i  [2];
   logic [63:0] ev_data_i  [2];
   logic        ready_i    [2];

   logic        o_valid [2];
   logic [1:0]  o_cls   [2];
   logic [7:0]  o_inst  [2];
   logic [31:0] o_ts    [2];
   logic [63:0] o_data  [2];
   logic        o_drop  [2];
   logic [31:0] o_dtot  [2];
   logic [6:0]  fill0;
   logic [2:0]  fill1;

   ofs_plat_log_trace_drain #(.DEPTH(64), .DATA_WIDTH(64), .INST_WIDTH(8), .TS_WIDTH(32)) u_dut64 (
      .clk(clk), .reset(reset), .flush(flush_i[0]),
      .ev_valid(ev_valid_i[0]), .ev_class(ev_class_i[0]), .ev_instance(ev_inst_i[0]), .ev_data(ev_data_i[0]),
      .out_valid(o_valid[0]), .out_ready(ready_i[0]), .out_class(o_cls[0]), .out_instance(o_inst[0]),
      .out_ts(o_ts[0]), .out_data(o_data[0]), .out_is_drop(o_drop[0]),
      .fill_level(fill0), .drop_total(o_dtot[0])
   );

   ofs_plat_log_trace_drain #(.DEPTH(4), .DATA_WIDTH(64), .INST_WIDTH(8), .TS_WIDTH(32)) u_dut4 (
      .clk(clk), .reset(reset), .flush(flush_i[1]),
      .ev_valid(ev_valid_i[1]), .ev_class(ev_class_i[1]), .ev_instance(ev_inst_i[1]), .ev_data(ev_data_i[1]),
      .out_valid(o_valid[1]), .out_ready(ready_i[1]), .out_class(o_cls[1]), .out_instance(o_inst[1]),
      .out_ts(o_ts[1]), .out_data(o_data[1]), .out_is_drop(o_drop[1]),
      .fill_level(fill1), .drop_total(o_dtot[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: one queue of records per instance ----------------
   rec_t          mq [2][$];
   int unsigned   pend [2];
   logic [31:0]   dtot [2];
   logic [31:0]   mts;

   function automatic int depth_of(input int k);
      return (k == 0) ? 64 : 4;
   endfunction

   function automatic void model_step(input int k);
      bit   real_ev, full, pop, push, dropped;
      rec_t r;
      real_ev = ev_valid_i[k] && (ev_class_i[k] != 2'd0);
      if (flush_i[k]) begin
         mq[k].delete();
         pend[k] = 0;
         return;
      end
      full    = (mq[k].size() == depth_of(k));
      pop     = (mq[k].size() != 0) && ready_i[k];
      push    = 0;
      dropped = 0;
      r       = '0;
      if (!full && pend[k] != 0) begin
         r.drop  = 1'b1;
         r.ts    = mts;
         r.data  = 64'(pend[k]);
         push    = 1;
         dropped = real_ev;
         pend[k] = dropped ? 1 : 0;
      end else if (real_ev) begin
         if (full) begin
            dropped = 1;
            if (pend[k] < 65535) pend[k]++;
         end else begin
            r.cls  = ev_class_i[k];
            r.inst = ev_inst_i[k];
            r.ts   = mts;
            r.data = ev_data_i[k];
            push   = 1;
         end
      end
      if (dropped && dtot[k] != 32'hFFFF_FFFF) dtot[k]++;
      if (pop) void'(mq[k].pop_front());
      if (push) mq[k].push_back(r);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            pend[k] = 0;
            dtot[k] = 32'd0;
         end
         mts = 32'd0;
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
         mts = mts + 32'd1;
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   always @(negedge clk) begin : cmp
      rec_t h;
      logic [63:0] fl;
      for (int k = 0; k < 2; k++) begin
         h  = (mq[k].size() != 0) ? mq[k][0] : '0;
         fl = (k == 0) ? 64'(fill0) : 64'(fill1);
         check($sformatf("i%0d.out_valid", k),   64'(o_valid[k]), 64'(mq[k].size() != 0));
         check($sformatf("i%0d.out_class", k),   64'(o_cls[k]),   64'(h.cls));
         check($sformatf("i%0d.out_instance", k), 64'(o_inst[k]), 64'(h.inst));
         check($sformatf("i%0d.out_ts", k),      64'(o_ts[k]),    64'(h.ts));
         check($sformatf("i%0d.out_data", k),    o_data[k],       h.data);
         check($sformatf("i%0d.out_is_drop", k), 64'(o_drop[k]),  64'(h.drop));
         check($sformatf("i%0d.fill_level", k),  fl,              64'(mq[k].size()));
         check($sformatf("i%0d.drop_total", k),  64'(o_dtot[k]),  64'(dtot[k]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      flush_i[k]    = 1'b0;
      ev_valid_i[k] = 1'b0;
      ev_class_i[k] = 2'd0;
      ev_inst_i[k]  = 8'd0;
      ev_data_i[k]  = 64'd0;
   endtask

   task automatic put_ev(input int k, input logic [1:0] c, input logic [7:0] i, input logic [63:0] d);
      ev_valid_i[k] = 1'b1;
      ev_class_i[k] = c;
      ev_inst_i[k]  = i;
      ev_data_i[k]  = d;
   endtask

   function automatic rec_t cur_rec(input int k);
      rec_t r;
      r.drop = o_drop[k];
      r.cls  = o_cls[k];
      r.inst = o_inst[k];
      r.ts   = o_ts[k];
      r.data = o_data[k];
      return r;
   endfunction

   rec_t got [$];

   // Drain instance k with ready held high, collecting up to n records within a cycle budget.
   task automatic collect(input int k, input int n, input int budget);
      got.delete();
      ready_i[k] = 1'b1;
      for (int c = 0; c < budget && got.size() < n; c++) begin
         if (o_valid[k]) got.push_back(cur_rec(k));
         tick();
      end
   endtask

   int          injected, ev_cnt;
   longint      mk_sum, last_data;
   logic [31:0] exp_dtot, exp_ts;

   task automatic account0();
      if (o_valid[0] && ready_i[0]) begin
         if (o_drop[0]) mk_sum += longint'(o_data[0]);
         else begin
            check("t5.order", 64'(longint'(o_data[0]) > last_data), 64'd1);
            last_data = longint'(o_data[0]);
            ev_cnt++;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         idle(k);
         ready_i[k] = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.out_valid", 64'(o_valid[0]), 64'd0);
      check("reset.fill_level", 64'(fill0), 64'd0);
      reset = 1'b0;

      // T1: single HOST_CHAN event in timestamp cycle 10
      repeat (10) tick();
      put_ev(0, 2'd1, 8'd3, 64'hABCD);
      ready_i[0] = 1'b1;
      tick();
      idle(0);
      check("t1.out_valid", 64'(o_valid[0]), 64'd1);
      check("t1.out_class", 64'(o_cls[0]), 64'd1);
      check("t1.out_instance", 64'(o_inst[0]), 64'd3);
      check("t1.out_data", o_data[0], 64'hABCD);
      check("t1.out_ts", 64'(o_ts[0]), 64'd10);
      check("t1.out_is_drop", 64'(o_drop[0]), 64'd0);
      tick();
      check("t1.fill_after", 64'(fill0), 64'd0);

      // T2: DEPTH=4, 7 LOCAL_MEM events with reader stalled
      ready_i[1] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         put_ev(1, 2'd2, 8'd1, 64'(i));
         tick();
      end
      idle(1);
      check("t2.fill_level", 64'(fill1), 64'd4);
      check("t2.drop_total", 64'(o_dtot[1]), 64'd3);
      collect(1, 5, 20);
      check("t2.record_count", 64'(got.size()), 64'd5);
      for (int i = 0; i < got.size(); i++) begin
         if (i < 4) begin
            check($sformatf("t2.rec%0d.is_drop", i), 64'(got[i].drop), 64'd0);
            check($sformatf("t2.rec%0d.class", i), 64'(got[i].cls), 64'd2);
            check($sformatf("t2.rec%0d.data", i), got[i].data, 64'(i));
         end else begin
            check("t2.marker.is_drop", 64'(got[i].drop), 64'd1);
            check("t2.marker.class", 64'(got[i].cls), 64'd0);
            check("t2.marker.data", got[i].data, 64'd3);
         end
      end
      tick();
      check("t2.fill_after", 64'(fill1), 64'd0);

      // T3: marker collides with an incoming event
      flush_i[1] = 1'b1;
      tick();
      flush_i[1] = 1'b0;
      ready_i[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         put_ev(1, 2'd2, 8'd2, 64'(10 + i));
         tick();
      end
      idle(1);
      check("t3.drop_total_full", 64'(o_dtot[1]), 64'd5);
      ready_i[1] = 1'b1;
      tick();
      ready_i[1] = 1'b0;
      put_ev(1, 2'd2, 8'd2, 64'd99);
      tick();
      idle(1);
      check("t3.drop_total_collide", 64'(o_dtot[1]), 64'd6);
      check("t3.fill_level", 64'(fill1), 64'd4);
      collect(1, 5, 30);
      check("t3.record_count", 64'(got.size()), 64'd5);
      for (int i = 0; i < got.size(); i++) begin
         if (i < 3) begin
            check($sformatf("t3.rec%0d.is_drop", i), 64'(got[i].drop), 64'd0);
            check($sformatf("t3.rec%0d.data", i), got[i].data, 64'(11 + i));
         end else begin
            check($sformatf("t3.marker%0d.is_drop", i), 64'(got[i].drop), 64'd1);
            check($sformatf("t3.marker%0d.data", i), got[i].data, (i == 3) ? 64'd2 : 64'd1);
         end
      end
      ready_i[1] = 1'b0;

      // T4: class-0 events are ignored
      ready_i[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         put_ev(0, 2'd0, 8'($urandom_range(0, 255)), {$urandom, $urandom});
         tick();
         check("t4.out_valid", 64'(o_valid[0]), 64'd0);
      end
      idle(0);
      check("t4.drop_total", 64'(o_dtot[0]), 64'd0);

      // T5: random traffic on both instances, 1000 HSSI events into the deep ring
      injected  = 0;
      ev_cnt    = 0;
      mk_sum    = 0;
      last_data = -1;
      for (int c = 0; c < 6000 && injected < 1000; c++) begin
         ready_i[0] = 1'($urandom_range(0, 1));
         account0();
         idle(0);
         if ($urandom_range(0, 1) == 1) begin
            put_ev(0, 2'd3, 8'($urandom_range(0, 255)), 64'(injected));
            injected++;
         end
         ready_i[1]    = 1'($urandom_range(0, 1));
         flush_i[1]    = ($urandom_range(0, 49) == 0);
         ev_valid_i[1] = 1'($urandom_range(0, 1));
         ev_class_i[1] = 2'($urandom_range(0, 3));
         ev_inst_i[1]  = 8'($urandom_range(0, 255));
         ev_data_i[1]  = {$urandom, $urandom};
         tick();
      end
      idle(0);
      idle(1);
      for (int c = 0; c < 300; c++) begin
         ready_i[0] = 1'b1;
         ready_i[1] = 1'b1;
         account0();
         tick();
      end
      check("t5.injected", 64'(injected), 64'd1000);
      check("t5.accounted", 64'(longint'(ev_cnt) + mk_sum), 64'(injected));
      check("t5.fill_after", 64'(fill0), 64'd0);

      // T6: flush with a full shallow ring and pending drops
      flush_i[1] = 1'b1;
      tick();
      flush_i[1] = 1'b0;
      ready_i[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         put_ev(1, 2'd1, 8'd5, 64'(i));
         tick();
      end
      check("t6.fill_before", 64'(fill1), 64'd4);
      exp_dtot   = dtot[1];
      flush_i[1] = 1'b1;
      tick();
      idle(1);
      check("t6.fill_after", 64'(fill1), 64'd0);
      check("t6.out_valid", 64'(o_valid[1]), 64'd0);
      check("t6.drop_total_kept", 64'(o_dtot[1]), 64'(exp_dtot));
      put_ev(1, 2'd3, 8'd7, 64'h55);
      exp_ts = mts;
      tick();
      idle(1);
      check("t6.next.is_drop", 64'(o_drop[1]), 64'd0);
      check("t6.next.data", o_data[1], 64'h55);
      check("t6.next.ts", 64'(o_ts[1]), 64'(exp_ts));

      // T7: asynchronous reset while draining
      ready_i[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         put_ev(0, 2'd3, 8'd9, 64'(100 + i));
         tick();
      end
      idle(0);
      check("t7.fill_before", 64'(fill0), 64'd3);
      ready_i[0] = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("t7.i%0d.out_valid", k), 64'(o_valid[k]), 64'd0);
         check($sformatf("t7.i%0d.out_data", k), o_data[k], 64'd0);
         check($sformatf("t7.i%0d.out_ts", k), 64'(o_ts[k]), 64'd0);
         check($sformatf("t7.i%0d.drop_total", k), 64'(o_dtot[k]), 64'd0);
      end
      check("t7.fill0", 64'(fill0), 64'd0);
      check("t7.fill1", 64'(fill1), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
